fft_sequencer: RTL and testbench

Controller that schedules an in-place, iterative radix-2 decimation-in-time FFT over one shared, pipelined butterfly datapath and a single dual-port sample memory. On `start` it walks all log2(N) stages. For each butterfly it issues the two memory read addresses and the twiddle index, then returns the matching write addresses once the datapath latency has elapsed. It sits between the host/control logic and the butterfly + memory pair, and owns all stage/pair sequencing and read-after-write hazard avoidance between stages.

---
 rtl/fft_sequencer_if.sv | 29 ++
 rtl/fft_sequencer.sv | 109 ++++++++++
 tb/tb_fft_sequencer.sv | 192 +++++++++++++++++++
 3 files changed

// File: rtl/fft_sequencer_if.sv
// fft_sequencer_if: start/status, read-pair and write-pair bundle between the FFT sequencer and its host/datapath
interface fft_sequencer_if #(
    parameter int N = 8
) ();
    localparam int LOGN = $clog2(N);
    localparam int SW   = ($clog2(LOGN) > 1) ? $clog2(LOGN) : 1;

    logic            start;
    logic            busy;
    logic            done;
    logic            rd_en;
    logic [LOGN-1:0] rd_a;
    logic [LOGN-1:0] rd_b;
    logic [LOGN-2:0] tw_idx;
    logic [SW-1:0]   stage;
    logic            wr_en;
    logic [LOGN-1:0] wr_a;
    logic [LOGN-1:0] wr_b;

    modport master (
        input  start,
        output busy, done, rd_en, rd_a, rd_b, tw_idx, stage, wr_en, wr_a, wr_b
    );

    modport slave (
        output start,
        input  busy, done, rd_en, rd_a, rd_b, tw_idx, stage, wr_en, wr_a, wr_b
    );
endinterface

// File: rtl/fft_sequencer.sv
// fft_sequencer: stage/pair scheduler for an in-place radix-2 DIT FFT over one pipelined butterfly
module fft_sequencer #(
    parameter int N   = 8,
    parameter int LAT = 1
) (
    input  logic            clk,
    input  logic            rst_n,
    fft_sequencer_if.master bus
);
    localparam int LOGN = $clog2(N);
    localparam int SW   = ($clog2(LOGN) > 1) ? $clog2(LOGN) : 1;
    localparam int JW   = LOGN - 1;
    localparam int DW   = $clog2(LAT + 2);
    localparam logic [JW-1:0] J_LAST = JW'(N / 2 - 1);
    localparam logic [DW-1:0] D_LAST = DW'(LAT);
    localparam logic [SW-1:0] S_LAST = SW'(LOGN - 1);

    typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, DONE} state_t;

    state_t                 r_state, w_state_nxt;
    logic [SW-1:0]          r_s, w_s_nxt;
    logic [JW-1:0]          r_j, w_j_nxt;
    logic [DW-1:0]          r_d, w_d_nxt;
    logic                   w_rd_en, w_busy;
    logic [LOGN-1:0]        w_jx, w_h, w_p, w_g, w_a, w_rd_a, w_rd_b;
    logic [JW-1:0]          w_tw;
    logic [SW-1:0]          w_tsh;
    logic [LAT:0]           r_pv;
    logic [LAT:0][LOGN-1:0] r_pa, r_pb;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= IDLE;
            r_s     <= '0;
            r_j     <= '0;
            r_d     <= '0;
            r_pv    <= '0;
            r_pa    <= '0;
            r_pb    <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_s     <= w_s_nxt;
            r_j     <= w_j_nxt;
            r_d     <= w_d_nxt;
            r_pv[0] <= w_rd_en;
            r_pa[0] <= w_rd_a;
            r_pb[0] <= w_rd_b;
            for (int i = 1; i <= LAT; i++) begin
                r_pv[i] <= r_pv[i-1];
                r_pa[i] <= r_pa[i-1];
                r_pb[i] <= r_pb[i-1];
            end
        end
    end

    // DRAIN holds off the next stage until its last write has left the pipe
    always_comb begin
        w_state_nxt = r_state;
        w_s_nxt     = r_s;
        w_j_nxt     = r_j;
        w_d_nxt     = r_d;
        case (r_state)
            IDLE: if (bus.start) begin
                w_state_nxt = ISSUE;
                w_s_nxt     = '0;
                w_j_nxt     = '0;
            end
            ISSUE: if (r_j == J_LAST) begin
                w_state_nxt = DRAIN;
                w_d_nxt     = '0;
            end else begin
                w_j_nxt = r_j + 1'b1;
            end
            DRAIN: if (r_d != D_LAST) begin
                w_d_nxt = r_d + 1'b1;
            end else if (r_s != S_LAST) begin
                w_state_nxt = ISSUE;
                w_s_nxt     = r_s + 1'b1;
                w_j_nxt     = '0;
            end else begin
                w_state_nxt = DONE;
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    assign w_rd_en = (r_state == ISSUE);
    assign w_busy  = (r_state == ISSUE) || (r_state == DRAIN);
    assign w_jx    = {1'b0, r_j};
    assign w_h     = LOGN'(1) << r_s;
    assign w_p     = w_jx & (w_h - 1'b1);
    assign w_g     = w_jx >> r_s;
    assign w_a     = ((w_g << r_s) << 1) | w_p;
    assign w_tsh   = S_LAST - r_s;
    assign w_tw    = JW'(w_p << w_tsh);
    assign w_rd_a  = w_rd_en ? w_a : '0;
    assign w_rd_b  = w_rd_en ? (w_a | w_h) : '0;

    assign bus.busy   = w_busy;
    assign bus.done   = (r_state == DONE);
    assign bus.rd_en  = w_rd_en;
    assign bus.rd_a   = w_rd_a;
    assign bus.rd_b   = w_rd_b;
    assign bus.tw_idx = w_rd_en ? w_tw : '0;
    assign bus.stage  = w_busy ? r_s : '0;
    assign bus.wr_en  = r_pv[LAT];
    assign bus.wr_a   = r_pa[LAT];
    assign bus.wr_b   = r_pb[LAT];
endmodule

// File: tb/tb_fft_sequencer.sv
// tb_fft_sequencer: directed checks of an N=8/LAT=1 and an N=16/LAT=3 sequencer, with a butterfly+memory model on the first
module tb_fft_sequencer;
    typedef struct {
        int t;
        int ra;
        int rb;
        int xr;
        int xi;
        int yr;
        int yi;
    } wr_t;

    logic clk = 1'b0;
    logic rst_n;
    int n_chk = 0, n_fail = 0, cyc = 0, s0;
    int n_busy, first_busy, n_done, done_cyc, n_rd, n_wr, last_wr;
    int n_busy2, n_done2, n_rd2, n_wr2, out2, last_st2;
    int mr[8], mi[8];
    int la[12], lb[12], lt[12], ls[12];
    int cw[4] = '{1024, 724, 0, -724};
    int sw[4] = '{0, -724, -1024, -724};
    int ea[12] = '{0, 2, 4, 6, 0, 1, 4, 5, 0, 1, 2, 3};
    int eb[12] = '{1, 3, 5, 7, 2, 3, 6, 7, 4, 5, 6, 7};
    int et[12] = '{0, 0, 0, 0, 0, 2, 0, 2, 0, 1, 2, 3};
    int es[12] = '{0, 0, 0, 0, 1, 1, 1, 1, 2, 2, 2, 2};
    wr_t q_a[$];
    wr_t q_b[$];

    fft_sequencer_if #(.N(8))  a ();
    fft_sequencer_if #(.N(16)) b ();

    fft_sequencer #(.N(8), .LAT(1)) u_a (.clk(clk), .rst_n(rst_n), .bus(a));
    fft_sequencer #(.N(16), .LAT(3)) u_b (.clk(clk), .rst_n(rst_n), .bus(b));

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Advance one cycle, then model memory + butterfly and score both sequencers
    task automatic tick();
        wr_t e;
        int ra, rb, k, pr, pim;
        @(posedge clk);
        #1;
        cyc++;
        if (a.wr_en) begin
            if (q_a.size() == 0) chk("wr_a_orphan", 1, 0);
            else begin
                e = q_a.pop_front();
                chk("wr_a_align", {8'(cyc - e.t), 8'(a.wr_a), 8'(a.wr_b)}, {8'd2, 8'(e.ra), 8'(e.rb)});
                mr[e.ra] = e.xr;
                mi[e.ra] = e.xi;
                mr[e.rb] = e.yr;
                mi[e.rb] = e.yi;
            end
            n_wr++;
            last_wr = cyc;
        end
        if (a.rd_en) begin
            ra = int'(a.rd_a);
            rb = int'(a.rd_b);
            k = int'(a.tw_idx);
            pr = (mr[rb] * cw[k] - mi[rb] * sw[k]) >>> 10;
            pim = (mr[rb] * sw[k] + mi[rb] * cw[k]) >>> 10;
            q_a.push_back('{cyc, ra, rb, mr[ra] + pr, mi[ra] + pim, mr[ra] - pr, mi[ra] - pim});
            if (n_rd < 12) begin
                la[n_rd] = ra;
                lb[n_rd] = rb;
                lt[n_rd] = k;
                ls[n_rd] = int'(a.stage);
            end
            n_rd++;
        end
        if (a.busy) begin
            n_busy++;
            if (first_busy < 0) first_busy = cyc;
        end
        if (a.done) begin
            n_done++;
            done_cyc = cyc;
        end
        if (b.rd_en) begin
            if (int'(b.stage) != last_st2) chk("raw_hazard_outstanding", 64'(out2), 0);
            last_st2 = int'(b.stage);
            q_b.push_back('{cyc, int'(b.rd_a), int'(b.rd_b), 0, 0, 0, 0});
            out2++;
            n_rd2++;
        end
        if (b.wr_en) begin
            if (q_b.size() == 0) chk("wr_b_orphan", 1, 0);
            else begin
                e = q_b.pop_front();
                chk("wr_b_align", {8'(cyc - e.t), 8'(b.wr_a), 8'(b.wr_b)}, {8'd4, 8'(e.ra), 8'(e.rb)});
            end
            out2--;
            n_wr2++;
        end
        if (b.busy) n_busy2++;
        if (b.done) n_done2++;
    endtask

    initial begin
        rst_n = 1'b0;
        a.start = 1'b1;
        b.start = 1'b1;
        for (int i = 0; i < 8; i++) begin
            mr[i] = 0;
            mi[i] = 0;
        end
        mr[0] = 1000;
        n_busy = 0; first_busy = -1; n_done = 0; done_cyc = -1; n_rd = 0; n_wr = 0; last_wr = -1;
        n_busy2 = 0; n_done2 = 0; n_rd2 = 0; n_wr2 = 0; out2 = 0; last_st2 = -1;
        repeat (3) begin
            tick();
            chk("rst_a_outputs", {a.busy, a.done, a.rd_en, a.wr_en, a.rd_a, a.rd_b, a.tw_idx, a.stage, a.wr_a, a.wr_b}, 0);
            chk("rst_b_outputs", {b.busy, b.done, b.rd_en, b.wr_en, b.rd_a, b.rd_b, b.tw_idx, b.stage, b.wr_a, b.wr_b}, 0);
        end
        rst_n = 1'b1;
        a.start = 1'b0;
        b.start = 1'b0;
        tick();
        tick();
        chk("idle_after_rst", {a.busy, b.busy, 6'(n_rd), 6'(n_rd2)}, 0);
        a.start = 1'b1;
        s0 = cyc;
        tick();
        chk("first_issue", {a.busy, a.rd_en, a.rd_a, a.rd_b, a.tw_idx, a.stage}, {1'b1, 1'b1, 3'd0, 3'd1, 2'd0, 2'd0});
        a.start = 1'b0;
        tick();
        a.start = 1'b1;
        tick();
        a.start = 1'b0;
        repeat (15) tick();
        chk("last_busy_cycle", {a.busy, a.done}, 2'b10);
        tick();
        chk("done_pulse", {a.busy, a.done}, 2'b01);
        a.start = 1'b1;
        tick();
        chk("idle_after_done", {a.busy, a.done, a.rd_en}, 3'b000);
        chk("busy_cycles", 64'(n_busy), 18);
        chk("busy_start_cycle", 64'(first_busy - s0), 1);
        chk("done_count", 64'(n_done), 1);
        chk("done_cycle", 64'(done_cyc - s0), 19);
        chk("read_count", 64'(n_rd), 12);
        chk("write_count", 64'(n_wr), 12);
        chk("last_wr_is_last_drain", 64'(last_wr - s0), 18);
        chk("wr_queue_empty", 64'(q_a.size()), 0);
        for (int i = 0; i < 12; i++)
            chk($sformatf("rd_seq%0d", i), {8'(la[i]), 8'(lb[i]), 8'(lt[i]), 8'(ls[i])},
                {8'(ea[i]), 8'(eb[i]), 8'(et[i]), 8'(es[i])});
        for (int i = 0; i < 8; i++)
            chk($sformatf("fft_out%0d", i), {32'(mr[i]), 32'(mi[i])}, {32'd1000, 32'd0});
        tick();
        chk("restart_after_done", {a.busy, a.rd_en, a.rd_a, a.rd_b}, {1'b1, 1'b1, 3'd0, 3'd1});
        a.start = 1'b0;
        repeat (6) tick();
        chk("in_stage1_issue", {a.rd_en, a.stage, a.rd_a, a.rd_b}, {1'b1, 2'd1, 3'd0, 3'd2});
        rst_n = 1'b0;
        tick();
        chk("mid_rst_outputs", {a.busy, a.rd_en, a.wr_en, a.done}, 0);
        rst_n = 1'b1;
        q_a.delete();
        n_wr = 0;
        repeat (4) tick();
        chk("no_wr_after_rst", 64'(n_wr), 0);
        n_done = 0;
        a.start = 1'b1;
        tick();
        chk("rst_restart_stage0", {a.busy, a.rd_en, a.rd_a, a.rd_b, a.tw_idx, a.stage}, {1'b1, 1'b1, 3'd0, 3'd1, 2'd0, 2'd0});
        a.start = 1'b0;
        repeat (18) tick();
        chk("rst_run_done", {a.done, 8'(n_done), 8'(n_wr)}, {1'b1, 8'd1, 8'd12});
        b.start = 1'b1;
        tick();
        chk("n16_first_issue", {b.busy, b.rd_en, b.rd_a, b.rd_b}, {1'b1, 1'b1, 4'd0, 4'd1});
        b.start = 1'b0;
        repeat (55) tick();
        chk("n16_reads", 64'(n_rd2), 32);
        chk("n16_writes", 64'(n_wr2), 32);
        chk("n16_busy_cycles", 64'(n_busy2), 48);
        chk("n16_done_count", 64'(n_done2), 1);
        chk("n16_queue_empty", 64'(q_b.size()), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
